// File: rtl/snake_pkg.sv
// snake_pkg: shared types for the snake body engine.
//   dir_t     : movement direction encoding (matches the 2-bit dir port)
//   status_t  : game state encoding (matches the 2-bit status port)
//   opposite_dir(d) : the reverse of direction d, used to drop U-turn requests
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } status_t;

  function automatic dir_t opposite_dir(input dir_t d);
    case (d)
      DIR_UP:   opposite_dir = DIR_DOWN;
      DIR_DOWN: opposite_dir = DIR_UP;
      DIR_LEFT: opposite_dir = DIR_RIGHT;
      default:  opposite_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// snake_cell_match: N-way parallel coordinate comparator.
// Ports:
//   seg_x/seg_y : N stored segment coordinates
//   mask        : per-entry enable; disabled entries never match
//   qx/qy       : coordinate under test
//   match       : per-entry match vector (combinational)
module snake_cell_match #(
  parameter int N  = 16,
  parameter int XW = 6,
  parameter int YW = 5
) (
  input  logic [N-1:0][XW-1:0] seg_x,
  input  logic [N-1:0][YW-1:0] seg_y,
  input  logic [N-1:0]         mask,
  input  logic [XW-1:0]        qx,
  input  logic [YW-1:0]        qy,
  output logic [N-1:0]         match
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      match[i] = mask[i] && (seg_x[i] == qx) && (seg_y[i] == qy);
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body shift buffer, direction arbitration,
// wall/self collision detection and registered per-cell occupancy query.
// Optional build macro: SNAKE_WRAP_EN (defined: walls wrap around instead
// of killing the snake).
// Ports:
//   clk, rst (async active-low)
//   step, dir_valid, dir, grow, restart : game control inputs
//   query_x/query_y -> query_hit/query_head : 1-cycle-latency cell lookup
//   head_x/head_y, length, full, hit_wall, hit_body, status : game state
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  input  logic                         dir_valid,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  input  logic                         restart,
  input  logic [$clog2(GRID_W)-1:0]    query_x,
  input  logic [$clog2(GRID_H)-1:0]    query_y,
  output logic                         query_hit,
  output logic                         query_head,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         full,
  output logic                         hit_wall,
  output logic                         hit_body,
  output logic [1:0]                   status
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [MAX_LEN-1:0][XW-1:0] seg_x, init_x;
  logic [MAX_LEN-1:0][YW-1:0] seg_y, init_y;
  logic [MAX_LEN-1:0]         body_mask, occ_mask, body_match, occ_match;
  logic [XW-1:0]              nh_x;
  logic [YW-1:0]              nh_y;
  logic                       at_edge, wall, grow_eff, full_i, dir_ok;
  dir_t                       pend_dir, cur_dir;
  status_t                    st;
  logic                       grow_pend;

  assign head_x   = seg_x[0];
  assign head_y   = seg_y[0];
  assign full_i   = (length == LW'(MAX_LEN));
  assign full     = full_i;
  assign status   = st;
  assign grow_eff = grow_pend | grow;
  assign wall     = at_edge && !WRAP;
  assign dir_ok   = (dir_t'(dir) != opposite_dir(cur_dir));

  // Horizontal line centred on the grid, head at GRID_W/2, trailing left.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      init_x[i] = (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
      init_y[i] = YW'(GRID_H / 2);
    end
  end

  // Next head; at_edge marks a move off the grid, in which case nh holds
  // the wrapped coordinate (only used when wrapping is enabled).
  always_comb begin
    nh_x    = seg_x[0];
    nh_y    = seg_y[0];
    at_edge = 1'b0;
    case (pend_dir)
      DIR_UP:
        if (seg_y[0] == '0) begin at_edge = 1'b1; nh_y = Y_MAX; end
        else nh_y = seg_y[0] - Y_ONE;
      DIR_DOWN:
        if (seg_y[0] == Y_MAX) begin at_edge = 1'b1; nh_y = '0; end
        else nh_y = seg_y[0] + Y_ONE;
      DIR_LEFT:
        if (seg_x[0] == '0) begin at_edge = 1'b1; nh_x = X_MAX; end
        else nh_x = seg_x[0] - X_ONE;
      default:
        if (seg_x[0] == X_MAX) begin at_edge = 1'b1; nh_x = '0; end
        else nh_x = seg_x[0] + X_ONE;
    endcase
  end

  // The tail moves out of the way on a normal step, so it only blocks the
  // new head when it is retained (growing or already at full length).
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      occ_mask[i]  = (i < int'(length));
      body_mask[i] = (i < int'(length) - 1) ||
                     ((i == int'(length) - 1) && (grow_eff || full_i));
    end
  end

  snake_cell_match #(.N(MAX_LEN), .XW(XW), .YW(YW)) u_body_match (
    .seg_x(seg_x), .seg_y(seg_y), .mask(body_mask),
    .qx(nh_x), .qy(nh_y), .match(body_match)
  );

  snake_cell_match #(.N(MAX_LEN), .XW(XW), .YW(YW)) u_query_match (
    .seg_x(seg_x), .seg_y(seg_y), .mask(occ_mask),
    .qx(query_x), .qy(query_y), .match(occ_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_x <= init_x; seg_y <= init_y;
      length <= LW'(INIT_LEN);
      pend_dir <= DIR_RIGHT; cur_dir <= DIR_RIGHT;
      grow_pend <= 1'b0; st <= ST_IDLE;
      hit_wall <= 1'b0; hit_body <= 1'b0;
      query_hit <= 1'b0; query_head <= 1'b0;
    end else if (restart) begin
      seg_x <= init_x; seg_y <= init_y;
      length <= LW'(INIT_LEN);
      pend_dir <= DIR_RIGHT; cur_dir <= DIR_RIGHT;
      grow_pend <= 1'b0; st <= ST_IDLE;
      hit_wall <= 1'b0; hit_body <= 1'b0;
      query_hit <= 1'b0; query_head <= 1'b0;
    end else begin
      query_hit  <= |occ_match;
      query_head <= occ_match[0];
      if (grow) grow_pend <= 1'b1;
      // A same-cycle step below still moves with the old pending dir.
      if (dir_valid && dir_ok) begin
        pend_dir <= dir_t'(dir);
        if (st == ST_IDLE) st <= ST_RUN;
      end
      if (step && st == ST_RUN) begin
        cur_dir   <= pend_dir;
        grow_pend <= 1'b0;
        if (wall) begin
          hit_wall <= 1'b1;
          st       <= ST_DEAD;
        end else if (|body_match) begin
          hit_body <= 1'b1;
          st       <= ST_DEAD;
        end else begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          if (grow_eff && !full_i) length <= length + LW'(1);
        end
      end
    end
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
Parametrised snake body datapath and game FSM, the next-generation replacement for the fixed-size movement logic under top_greedy_snake.
- Stores up to MAX_LEN segment coordinates in a shift buffer and advances them on a step tick.
- Arbitrates direction requests and detects wall and self collisions.
- Answers per-cell occupancy queries for the VGA renderer with fixed 1-cycle latency.

Parameters:
GRID_W, 40, playfield width in cells
GRID_H, 30, playfield height in cells
MAX_LEN, 16, maximum segment count (>= INIT_LEN+1)
INIT_LEN, 3, length after reset/restart (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
step  in  1  one-cycle move tick
dir_valid  in  1  direction request strobe
dir  in  2  0=up 1=down 2=left 3=right
grow  in  1  extend on the next step (sticky until consumed)
restart  in  1  re-initialise body, return to IDLE
query_x  in  XW  cell column to test, XW=$clog2(GRID_W)
query_y  in  YW  cell row to test, YW=$clog2(GRID_H)
query_hit  out  1  queried cell holds a segment (registered)
query_head  out  1  queried cell is the head (registered)
head_x  out  XW  head column
head_y  out  YW  head row
length  out  LW  current length, LW=$clog2(MAX_LEN+1)
full  out  1  length==MAX_LEN
hit_wall  out  1  sticky, set on wall death
hit_body  out  1  sticky, set on self-collision death
status  out  2  0=IDLE 1=RUN 2=DEAD

Behaviour:
- Reset / restart init: seg[i]=(GRID_W/2-i, GRID_H/2) for i<INIT_LEN; committed dir=right; pending dir=right; grow_pend=0; length=INIT_LEN; hit_*=0; status=IDLE; query_*=0.
- restart has highest priority. It performs the same init synchronously in one cycle, overriding step/dir/grow in that cycle.
- Direction: a dir_valid whose dir is the opposite of the committed dir is dropped. Otherwise it overwrites pending dir, so the last legal request before a step wins.
  - In IDLE, an accepted dir_valid also moves status to RUN.
  - step and dir_valid in the same cycle: the step uses the old pending dir; the new dir becomes pending for the following step.
- grow sets grow_pend. It is cleared by the step that consumes it. grow and step in the same cycle: growth applies to that step.
- Step (RUN only; ignored in IDLE/DEAD):
  - nh = head ± 1 on the pending axis; committed dir <= pending dir.
  - Wall: nh outside [0,GRID_W-1]x[0,GRID_H-1] -> hit_wall=1, status=DEAD, body frozen (head stays at edge).
  - Body: compare nh against seg[0..length-2]. Also compare seg[length-1] when growing, or when full (the tail is retained). Any match -> hit_body=1, DEAD, frozen.
  - Otherwise seg[i]<=seg[i-1] for i>=1, seg[0]<=nh. If grow_pend and length<MAX_LEN, length+1. At MAX_LEN growth is discarded and length saturates.
- All comparisons are parallel, with a single-cycle decision. Entries at index >= length are don't-care and never match.
- Query: query_hit/query_head reflect query_x/y sampled at edge N, valid after edge N+1 (1-cycle latency). The result uses the body state as of edge N.
- DEAD holds until restart; hit_* remain set.

Optional Feature:
SNAKE_WRAP_EN
- Defined: wall exits wrap (x=GRID_W-1 right -> 0, x=0 left -> GRID_W-1, likewise y). hit_wall is never set; the body check applies to the wrapped coordinate.
- Undefined: wall death as above.

Decomposition:
- Package snake_pkg: direction enum (DIR_UP..DIR_RIGHT), status enum (ST_IDLE/ST_RUN/ST_DEAD), and the opposite-direction function.
- One sub-module, snake_cell_match: parameterised N-way coordinate comparator with length mask. It is instantiated twice: next-head collision and VGA query.

Test Plan:
1. Defaults, reset release, dir_valid up, step -> head (20,14), seg1 (20,15), seg2 (19,15), length 3, status RUN.
2. RUN heading right, dir_valid left then step -> request dropped, head x increments by 1; same cycle step+dir_valid up -> this step right, next step up.
3. From (20,15) heading right, 19 steps -> head (39,15); 20th step -> hit_wall=1, DEAD, head stays (39,15). With SNAKE_WRAP_EN the 20th step gives head (0,15) and status RUN.
4. grow held across 14 steps from INIT_LEN=3 -> length 16, full=1 after 13th, length stays 16 after 14th, no collision.
5. Length 5 heading right: up, left, down steps -> third step hit_body=1. Same sequence at length 4 -> no hit (tail vacates).
6. After reset, query (19,15) at edge N -> query_hit=1, query_head=0 at N+1. Query (20,15) -> both 1. Query (0,0) -> both 0. Restart mid-RUN -> body re-initialised next cycle, status IDLE.
